laser_receiver: RTL and testbench
=================================

// Module: laser_receiver
//
// PURPOSE
// Receive end of the laser link: qualifies the raw photodiode/sensor input into hit events.
// Synchronises the async sensor, demands a sustained beam (rejects glitches and ambient flicker),
// emits a 1-cycle hit pulse, counts hits, then enforces a lockout and beam-release window.
// Sits between the target sensor pin and the scoring/display logic.
//
// PARAMETERS
// SYNC_STAGES   2           flops in sensor synchroniser (>=2)
// SENSOR_ACT_LO 0           1 = sensor pin low means beam present
// MIN_ON        1000        consecutive synced-present cycles required to declare a hit (>=1)
// MIN_OFF       1000        consecutive synced-absent cycles required to re-arm (>=1)
// LOCKOUT       50_000_000  cycles after a hit during which no further hit is accepted (>=1)
// CNT_W         8           width of hit counter
//
// PORTS
// clk        in   1      system clock
// rst        in   1      synchronous, active-high reset
// sensor     in   1      raw asynchronous sensor pin
// enable     in   1      1 = receiver armed; 0 = forced to IDLE, no hits
// clr_count  in   1      synchronous clear of hit_count
// beam       out  1      synchronised, polarity-corrected beam-present level
// hit        out  1      1-cycle pulse per qualified hit (registered)
// busy       out  1      1 while in LOCKOUT or RELEASE
// hit_count  out  CNT_W  saturating hit counter
//
// BEHAVIOUR
// - Reset: all sync flops 0 (post-polarity = absent), state IDLE, timer 0, beam=0, hit=0, busy=0, hit_count=0.
// - beam = last synchroniser stage XOR SENSOR_ACT_LO; latency SYNC_STAGES cycles from pin.
// - Single down-counter timer, width $clog2(max(MIN_ON,MIN_OFF,LOCKOUT)+1).
// - States:
//   IDLE:    beam=1 -> ARM, timer=MIN_ON-1. Else stay.
//   ARM:     beam=0 -> IDLE (glitch rejected, no hit). beam=1 & timer==0 -> HIT. else timer--.
//   HIT:     one cycle; hit=1; hit_count++ (saturates at 2^CNT_W-1); -> LOCKOUT, timer=LOCKOUT-1.
//   LOCKOUT: timer--; beam ignored; timer==0 -> RELEASE, timer=MIN_OFF-1.
//   RELEASE: beam=1 -> reload timer=MIN_OFF-1, stay. beam=0 & timer==0 -> IDLE. else timer--.
// - MIN_ON=1: hit pulses on the cycle after the first beam=1 cycle seen in IDLE... i.e. ARM lasts 1 cycle.
// - Hit latency: hit high exactly SYNC_STAGES+MIN_ON+1 clk edges after the edge that first samples the pin active.
// - Continuous beam never produces a second hit; beam must drop for MIN_OFF cycles after lockout.
// - enable=0 (any state, incl. mid-ARM or mid-LOCKOUT): next state IDLE, timer=0, hit=0; hit_count held.
// - clr_count: hit_count<=0 next cycle; if coincident with HIT, clear wins (count=0, hit still pulses).
// - rst mid-operation: identical to power-on reset on the next edge, overrides enable/clr_count.
// - busy is combinational decode of state (LOCKOUT|RELEASE); hit is a registered output.
//
// STRUCTURE
// - Shared include laser_defs.vh: state encodings (IDLE, ARM, HIT, LOCKOUT, RELEASE, 3-bit),
//   timer-width function, default timing constants reused by the fire side.
// - Sub-module laser_sync: SYNC_STAGES flop chain + polarity correction, output beam.
// - Remainder in laser_receiver: FSM, timer, saturating counter.
//
// TESTING  (use MIN_ON=4, MIN_OFF=3, LOCKOUT=10, SYNC_STAGES=2, CNT_W=2 for sims)
// 1 sensor high for 3 cycles then low -> no hit, state returns IDLE, hit_count=0.
// 2 sensor high held 40 cycles -> exactly one hit pulse, 7 edges after first active sample;
//   busy high from next cycle; no second hit while beam held; hit_count=1.
// 3 after lockout, sensor low 2 cycles, high 1, low 3, then high 4+ -> only second pulse qualifies after
//   full MIN_OFF low window; hit_count=2.
// 4 five qualified hits -> hit_count saturates at 3; clr_count on a HIT cycle -> hit_count=0, hit=1.
// 5 enable dropped mid-ARM and mid-LOCKOUT -> IDLE next cycle, busy=0, no hit; count unchanged.
// 6 rst asserted mid-LOCKOUT with sensor high -> all outputs reset values next edge; SENSOR_ACT_LO=1 run
//   repeats test 2 with inverted pin -> same response.

Source files
------------

// File: rtl/laser_receiver_pkg.sv
// Shared types and constants for the laser link receive path.
// State encodings, timer sizing helper and default timing values.
package laser_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_HIT  = 3'd2,
    ST_LOCK = 3'd3,
    ST_REL  = 3'd4
  } state_e;

  localparam int DEF_SYNC    = 2;
  localparam int DEF_MIN_ON  = 1000;
  localparam int DEF_MIN_OFF = 1000;
  localparam int DEF_LOCKOUT = 50_000_000;

  function automatic int tmr_w(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/laser_receiver_if.sv
// Sensor-side inputs and scoring-side outputs of the receiver.
// The scoring logic holds the master end, the receiver the slave end.
interface laser_receiver_if #(
  parameter int CNT_W = 8
);
  logic             sensor;
  logic             enable;
  logic             clr_count;
  logic             beam;
  logic             hit;
  logic             busy;
  logic [CNT_W-1:0] hit_count;

  modport master (
    output sensor, enable, clr_count,
    input  beam, hit, busy, hit_count
  );

  modport slave (
    input  sensor, enable, clr_count,
    output beam, hit, busy, hit_count
  );
endinterface

// File: rtl/laser_receiver_sync.sv
// Sensor pin synchroniser with polarity correction.
// Flops hold the corrected level so reset always reads as beam absent.
module laser_receiver_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter bit SENSOR_ACT_LO = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_i,
  output logic beam_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sensor_i ^ SENSOR_ACT_LO};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign beam_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/laser_receiver.sv
// Laser link receiver: qualifies a sustained beam into one hit,
// counts hits, then holds off through lockout and beam release.
module laser_receiver
  import laser_receiver_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC,
  parameter bit SENSOR_ACT_LO = 1'b0,
  parameter int MIN_ON        = DEF_MIN_ON,
  parameter int MIN_OFF       = DEF_MIN_OFF,
  parameter int LOCKOUT       = DEF_LOCKOUT,
  parameter int CNT_W         = 8
) (
  input logic              clk,
  input logic              rst,
  laser_receiver_if.slave  bus
);

  localparam int TW = tmr_w(MIN_ON, MIN_OFF, LOCKOUT);
  localparam logic [TW-1:0] T_ON  = TW'(MIN_ON - 1);
  localparam logic [TW-1:0] T_OFF = TW'(MIN_OFF - 1);
  localparam logic [TW-1:0] T_LCK = TW'(LOCKOUT - 1);
  localparam logic [TW-1:0] T_ONE = TW'(1);

  state_e           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beam;
  logic             busy;
  logic             tmr_done;

  laser_receiver_sync #(
    .SYNC_STAGES   (SYNC_STAGES),
    .SENSOR_ACT_LO (SENSOR_ACT_LO)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .sensor_i (bus.sensor),
    .beam_o   (beam)
  );

  assign tmr_done = (tmr_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    if (!bus.enable) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (beam) begin
            state_d = ST_ARM;
            tmr_d   = T_ON;
          end
        end
        ST_ARM: begin
          if (!beam)         state_d = ST_IDLE;
          else if (tmr_done) state_d = ST_HIT;
          else               tmr_d   = tmr_q - T_ONE;
        end
        ST_HIT: begin
          state_d = ST_LOCK;
          tmr_d   = T_LCK;
        end
        ST_LOCK: begin
          if (tmr_done) begin
            state_d = ST_REL;
            tmr_d   = T_OFF;
          end else begin
            tmr_d = tmr_q - T_ONE;
          end
        end
        ST_REL: begin
          // any beam sample restarts the dark window
          if (beam)          tmr_d   = T_OFF;
          else if (tmr_done) state_d = ST_IDLE;
          else               tmr_d   = tmr_q - T_ONE;
        end
        default: begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy  = (state_q == ST_LOCK) || (state_q == ST_REL);
    hit_d = (state_d == ST_HIT);
    cnt_d = cnt_q;
    if (bus.clr_count) begin
      cnt_d = '0;
    end else if (state_q == ST_HIT && bus.enable && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign bus.beam      = beam;
  assign bus.hit       = hit_q;
  assign bus.busy      = busy;
  assign bus.hit_count = cnt_q;

endmodule

// File: tb/tb_laser_receiver.sv
// Directed bench for laser_receiver: run-length model checked every
// cycle on both pin polarities, plus hand-computed literal checks.
module tb_laser_receiver;

  localparam int SS      = 2;
  localparam int MIN_ON  = 4;
  localparam int MIN_OFF = 3;
  localparam int LOCKOUT = 10;
  localparam int CW      = 2;
  localparam int CMAX    = (1 << CW) - 1;

  localparam int P_IDLE = 0;
  localparam int P_ARM  = 1;
  localparam int P_HIT  = 2;
  localparam int P_LOCK = 3;
  localparam int P_REL  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic p   = 1'b0;
  logic en  = 1'b1;
  logic clr = 1'b0;

  laser_receiver_if #(.CNT_W(CW)) if0 ();
  laser_receiver_if #(.CNT_W(CW)) if1 ();

  assign if0.sensor    = p;
  assign if0.enable    = en;
  assign if0.clr_count = clr;
  assign if1.sensor    = ~p;
  assign if1.enable    = en;
  assign if1.clr_count = clr;

  laser_receiver #(
    .SYNC_STAGES(SS), .SENSOR_ACT_LO(1'b0),
    .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF),
    .LOCKOUT(LOCKOUT), .CNT_W(CW)
  ) u0 (.clk(clk), .rst(rst), .bus(if0));

  laser_receiver #(
    .SYNC_STAGES(SS), .SENSOR_ACT_LO(1'b1),
    .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF),
    .LOCKOUT(LOCKOUT), .CNT_W(CW)
  ) u1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  // model: beam is the present level delayed SS samples; a hit needs
  // MIN_ON+1 consecutive present samples seen while armed, then
  // LOCKOUT cycles of hold-off, then MIN_OFF consecutive dark samples
  int cyc   = 0;
  int phase = P_IDLE;
  int run   = 0;
  int lrem  = 0;
  int cnt_m = 0;
  bit hit_m = 1'b0;
  bit busy_m = 1'b0;
  bit beam_m = 1'b0;
  bit m_sync [SS];

  always @(posedge clk) begin
    bit b;
    cyc++;
    if (rst) begin
      for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
      phase = P_IDLE;
      run   = 0;
      lrem  = 0;
      cnt_m = 0;
    end else begin
      b = m_sync[SS-1];
      if (clr) cnt_m = 0;
      else if (phase == P_HIT && en && cnt_m < CMAX) cnt_m++;
      if (!en) begin
        phase = P_IDLE;
      end else begin
        case (phase)
          P_IDLE: if (b) begin phase = P_ARM; run = 1; end
          P_ARM: begin
            if (!b) phase = P_IDLE;
            else begin
              run++;
              if (run == MIN_ON + 1) phase = P_HIT;
            end
          end
          P_HIT: begin phase = P_LOCK; lrem = LOCKOUT; end
          P_LOCK: begin
            lrem--;
            if (lrem == 0) begin phase = P_REL; run = 0; end
          end
          default: begin
            if (b) run = 0;
            else begin
              run++;
              if (run == MIN_OFF) phase = P_IDLE;
            end
          end
        endcase
      end
      for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = p;
    end
    hit_m  = (phase == P_HIT);
    busy_m = (phase == P_LOCK) || (phase == P_REL);
    beam_m = m_sync[SS-1];
  end

  int vectors   = 0;
  int miss      = 0;
  int hits_seen = 0;
  int last_hit  = -1;
  int k;

  task automatic cmp(input string nm, input logic b, input logic h,
                     input logic bz, input logic [CW-1:0] c);
    vectors++;
    if (b !== beam_m || h !== hit_m || bz !== busy_m ||
        c !== CW'(cnt_m)) begin
      miss++;
      $display("FAIL %s cyc=%0d got b/h/busy/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
               nm, cyc, b, h, bz, c, beam_m, hit_m, busy_m, cnt_m);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmp("dut_hi", if0.beam, if0.hit, if0.busy, if0.hit_count);
      cmp("dut_lo", if1.beam, if1.hit, if1.busy, if1.hit_count);
      if (if0.hit === 1'b1) begin
        hits_seen++;
        last_hit = cyc;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tick(3);
    chk("rst_count", int'(if0.hit_count), 0);
    chk("rst_busy", int'(if0.busy), 0);
    chk("rst_hit", int'(if0.hit), 0);
    rst = 1'b0;
    tick(2);

    // short flash is rejected
    p = 1'b1; tick(3);
    p = 1'b0; tick(10);
    chk("t1_hits", hits_seen, 0);
    chk("t1_count", int'(if0.hit_count), 0);

    // held beam: one hit, 7 edges counting the sampling edge
    k = cyc;
    p = 1'b1; tick(40);
    chk("t2_latency", last_hit - k, 7);
    chk("t2_hits", hits_seen, 1);
    chk("t2_count", int'(if0.hit_count), 1);
    chk("t2_count_lo", int'(if1.hit_count), 1);
    chk("t2_busy", int'(if0.busy), 1);

    // release window restarts on a one-cycle blip
    p = 1'b0; tick(2);
    p = 1'b1; tick(1);
    p = 1'b0; tick(3);
    p = 1'b1; tick(9);
    chk("t3_hits", hits_seen, 2);
    chk("t3_count", int'(if0.hit_count), 2);
    p = 1'b0; tick(16);

    // saturation at 3
    for (int j = 0; j < 3; j++) begin
      p = 1'b1; tick(8);
      p = 1'b0; tick(16);
    end
    chk("t4_hits", hits_seen, 5);
    chk("t4_sat", int'(if0.hit_count), 3);

    // clear on the hit cycle wins
    p = 1'b1; tick(7);
    chk("t4_clr_hit", int'(if0.hit), 1);
    clr = 1'b1; tick(1);
    clr = 1'b0;
    chk("t4_clr_count", int'(if0.hit_count), 0);
    p = 1'b0; tick(16);
    chk("t4_clr_hits", hits_seen, 6);

    // enable drop mid-ARM
    p = 1'b1; tick(4);
    en = 1'b0; p = 1'b0; tick(1);
    chk("t5_arm_busy", int'(if0.busy), 0);
    chk("t5_arm_hit", int'(if0.hit), 0);
    en = 1'b1; tick(12);
    chk("t5_arm_hits", hits_seen, 6);
    chk("t5_arm_count", int'(if0.hit_count), 0);

    // enable drop mid-LOCKOUT
    p = 1'b1; tick(8);
    p = 1'b0; tick(2);
    chk("t5_lock_busy1", int'(if0.busy), 1);
    en = 1'b0; tick(1);
    chk("t5_lock_busy0", int'(if0.busy), 0);
    en = 1'b1; tick(20);
    chk("t5_lock_hits", hits_seen, 7);
    chk("t5_lock_count", int'(if0.hit_count), 1);

    // reset mid-LOCKOUT with beam held
    p = 1'b1; tick(10);
    chk("t6_pre_busy", int'(if0.busy), 1);
    rst = 1'b1; tick(1);
    chk("t6_hit", int'(if0.hit), 0);
    chk("t6_busy", int'(if0.busy), 0);
    chk("t6_count", int'(if0.hit_count), 0);
    chk("t6_beam", int'(if0.beam), 0);
    chk("t6_beam_lo", int'(if1.beam), 0);
    rst = 1'b0; p = 1'b0; tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
